// File: rtl/ram_dp_clr.sv
// ram_dp_clr: single-clock dual-port RAM (one write port, one read port)
// with same-address write-to-read bypass, optional output register (OREG)
// and an optional post-reset zero-fill sequencer.
// Build option: define RAM_DP_CLR_CLEAR_EN to include the clear sequencer;
// without it busy is tied low and the array keeps its contents over reset.
module ram_dp_clr #(
  parameter int AW   = 17,
  parameter int DW   = 8,
  parameter int OREG = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          we,
  input  logic [AW-1:0] ra,
  input  logic          re,
  output logic [DW-1:0] rd,
  output logic          busy
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_s1;

  // Physical write port, shared between the clear sequencer and the user.
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;

`ifdef RAM_DP_CLR_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic          clr_we;

  // Clear sequencer state and address counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state: walk every address once, leave CLEAR after the last write.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    clr_we   = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        cnt_nx = cnt + 1'b1;
        if (cnt == '1) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  assign busy = (state == CLEAR);

  // Clear writes take the port whole; user writes only reach it in RUN.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wa;
    mem_wd = wd;
    if (!reset) begin
      if (clr_we) begin
        mem_we = 1'b1;
        mem_wa = cnt;
        mem_wd = '0;
      end else begin
        mem_we = we;
      end
    end
  end
`else
  assign busy = 1'b0;

  // Without the sequencer the user owns the write port outside reset.
  always_comb begin
    mem_we = we & ~reset;
    mem_wa = wa;
    mem_wd = wd;
  end
`endif

  // Array write; no reset of contents so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Read stage 1: zero unless an enabled read in RUN; same-address write bypasses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_s1 <= '0;
    end else if (re && !busy) begin
      if (we && (wa == ra)) rd_s1 <= wd;
      else                  rd_s1 <= mem[ra];
    end else begin
      rd_s1 <= '0;
    end
  end

  generate
    if (OREG != 0) begin : g_oreg
      logic [DW-1:0] rd_s2;

      // Optional output register, also zeroed by reset.
      always_ff @(posedge clk) begin
        if (reset) rd_s2 <= '0;
        else       rd_s2 <= rd_s1;
      end

      assign rd = rd_s2;
    end else begin : g_noreg
      assign rd = rd_s1;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_clr.sv
// Self-checking bench for ram_dp_clr (AW=4, DW=8), OREG=0 and OREG=1 side by side.
// Follows RAM_DP_CLR_CLEAR_EN the same way the design does.
module tb_ram_dp_clr;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] wa = '0;
  logic [7:0] wd = '0;
  logic       we = 1'b0;
  logic [3:0] ra = '0;
  logic       re = 1'b0;
  logic [7:0] rd0, rd1;
  logic       busy0, busy1;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0] mem [16];
  int         busy_cnt = 0;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  ram_dp_clr #(.AW(4), .DW(8), .OREG(0)) dut0 (
    .clk(clk), .reset(reset), .wa(wa), .wd(wd), .we(we),
    .ra(ra), .re(re), .rd(rd0), .busy(busy0)
  );

  ram_dp_clr #(.AW(4), .DW(8), .OREG(1)) dut1 (
    .clk(clk), .reset(reset), .wa(wa), .wd(wd), .we(we),
    .ra(ra), .re(re), .rd(rd1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop0(input logic [7:0] obs);
    if (q0.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL rd0_queue observed empty expected entry");
    end else begin
      chk("rd0", obs, q0.pop_front());
    end
  endtask

  task automatic chk_pop1(input logic [7:0] obs);
    if (q1.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL rd1_queue observed empty expected entry");
    end else begin
      chk("rd1", obs, q1.pop_front());
    end
  endtask

  // One RUN/CLEAR cycle: drive inputs, predict, clock, compare.
  task automatic step(input logic w, input logic [3:0] a_w, input logic [7:0] d_w,
                      input logic r, input logic [3:0] a_r);
    logic [7:0] e;
    logic       bexp;
    reset = 1'b0;
    we = w; wa = a_w; wd = d_w; re = r; ra = a_r;
    if (r && busy_cnt == 0) e = (w && a_w == a_r) ? d_w : mem[a_r];
    else                    e = 8'h00;
    q0.push_back(e);
    q1.push_back(e);
    if (busy_cnt > 0) begin
      mem[16 - busy_cnt] = 8'h00;
      busy_cnt--;
    end else if (w) begin
      mem[a_w] = d_w;
    end
    bexp = (busy_cnt != 0);
    @(posedge clk); #1;
    chk_pop0(rd0);
    chk_pop1(rd1);
    chk("busy0", {7'd0, busy0}, {7'd0, bexp});
    chk("busy1", {7'd0, busy1}, {7'd0, bexp});
  endtask

  // Hold reset for n cycles with a write to address 2 in flight (must be dropped).
  task automatic rst(input int n);
    logic bexp;
`ifdef RAM_DP_CLR_CLEAR_EN
    bexp = 1'b1;
`else
    bexp = 1'b0;
`endif
    reset = 1'b1;
    we = 1'b1; wa = 4'd2; wd = 8'hEE; re = 1'b1; ra = 4'd2;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("rst_rd0", rd0, 8'h00);
      chk("rst_rd1", rd1, 8'h00);
      chk("rst_busy0", {7'd0, busy0}, {7'd0, bexp});
      chk("rst_busy1", {7'd0, busy1}, {7'd0, bexp});
    end
    q0.delete();
    q1.delete();
    q1.push_back(8'h00);
    busy_cnt = bexp ? 16 : 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 'x;

`ifdef RAM_DP_CLR_CLEAR_EN
    // Busy masking: writes to 3 and reads during clear have no effect.
    rst(2);
    for (int i = 0; i < 16; i++) step(1'b1, 4'd3, 8'hFF, 1'b1, 4'(i));
    for (int i = 0; i < 16; i++) step(1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
    // Clear fill over a preloaded array.
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 8'hA5, 1'b0, 4'd0);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd9);
    rst(1);
    for (int i = 0; i < 16; i++) step(1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
    for (int i = 0; i < 16; i++) step(1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
    // Reset mid-clear restarts a full clear.
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 8'h5C, 1'b0, 4'd0);
    rst(1);
    for (int i = 0; i < 9; i++) step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    rst(1);
    for (int i = 0; i < 16; i++) step(1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
    for (int i = 0; i < 16; i++) step(1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
`else
    // No sequencer: contents survive reset, access right after release.
    rst(2);
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 8'(i * 17), 1'b0, 4'd0);
    step(1'b1, 4'd2, 8'h5A, 1'b0, 4'd0);
    rst(1);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd2);
    for (int i = 0; i < 16; i++) step(1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
`endif

    // Write then read latency, followed by a disabled read.
    step(1'b1, 4'd5, 8'h3C, 1'b0, 4'd0);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
    step(1'b0, 4'd0, 8'h00, 1'b0, 4'd5);
    step(1'b0, 4'd0, 8'h00, 1'b0, 4'd5);

    // Same-address bypass.
    step(1'b1, 4'd7, 8'h11, 1'b0, 4'd0);
    step(1'b1, 4'd7, 8'h99, 1'b1, 4'd7);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd7);
    step(1'b1, 4'd4, 8'h42, 1'b1, 4'd7);

    // Mixed random traffic, including read/write at different addresses.
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

    // Reset in RUN with a read in flight zeroes both pipelines.
    step(1'b1, 4'd6, 8'h77, 1'b0, 4'd0);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd6);
    rst(1);
    for (int i = 0; i < 18; i++) step(1'b0, 4'd0, 8'h00, 1'b1, 4'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
